// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MDU op encodings,
// MDU sequencer state type and default operation latencies.
package pipe_pkg;

    localparam logic [1:0] MDU_NONE = 2'b00;
    localparam logic [1:0] MDU_MULT = 2'b01;
    localparam logic [1:0] MDU_DIV  = 2'b10;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_seq.sv
// MDU sequencer: tracks a multi-cycle mult/div with a down-counter and
// reports busy for exactly N cycles, pulsing done on the last one.
module mdu_seq
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ex_mdu_start,
    output logic       mdu_busy,
    output logic       mdu_done
);

    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    mdu_state_e    state_r;
    mdu_state_e    state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    // next-state and counter update; starts while BUSY are ignored
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (ex_mdu_start == MDU_MULT) begin
                    state_s = BUSY;
                    cnt_s   = MULT_LOAD;
                end else if (ex_mdu_start == MDU_DIV) begin
                    state_s = BUSY;
                    cnt_s   = DIV_LOAD;
                end else begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = BUSY;
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    assign mdu_busy = (state_r == BUSY);
    assign mdu_done = (state_r == BUSY) && (cnt_r == CNT_ZERO);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use and MDU-busy stalls, taken-branch
// IF/ID flush, and a saturating count of stalled cycles.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int DELAY_SLOT  = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_mdu_use,
    input  logic             id_branch_taken,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic [1:0]       ex_mdu_start,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic             FLUSH_ON_BRANCH = (DELAY_SLOT == 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             load_use_s;
    logic             mdu_stall_s;
    logic             stall_s;
    logic [CNT_W-1:0] stall_cnt_r;

    mdu_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_seq (
        .clk          (clk),
        .reset        (reset),
        .ex_mdu_start (ex_mdu_start),
        .mdu_busy     (mdu_busy),
        .mdu_done     (mdu_done)
    );

    // $zero is never a real producer, so a load to r0 cannot create a hazard
    assign load_use_s  = ex_memread && (ex_rd != 5'd0) &&
                         ((id_rs_used && (id_rs == ex_rd)) ||
                          (id_rt_used && (id_rt == ex_rd)));
    assign mdu_stall_s = id_mdu_use && mdu_busy;
    assign stall_s     = load_use_s || mdu_stall_s;

    // pipeline controls; a stall overrides a branch flush so the branch re-resolves
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (reset) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end else begin
            pc_en      = ~stall_s;
            ifid_en    = ~stall_s;
            ifid_flush = id_branch_taken && ~stall_s && FLUSH_ON_BRANCH;
            idex_flush = stall_s;
        end
    end

    // saturating stalled-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule
